// File: rtl/modulation_swap_requester.sv
// Purpose: initiator side of the modulation segment-swap interface; validates one
//          swap command at a time and drives the swapchain settings inputs.
// Latency: accept at N, check at N+1, settings strobe at N+2, DONE combinational from N+3.
// Backpressure: CMD_READY is high only in IDLE; a command offered while busy is held off.
//
// Ports:
//   CLK, RST_N                       clock, asynchronous active-low reset
//   CMD_VALID/CMD_READY              command handshake
//   CMD_SEGMENT/MODE/VALUE/REP       command fields
//   SEGMENT, STOP                    swapchain status inputs
//   UPDATE_SETTINGS                  one-cycle strobe to the swapchain
//   REQ_RD_SEGMENT, TRANSITION_*     registered settings, held until the next strobe
//   REP                              per-segment repeat registers, 16 bits each
//   BUSY, DONE, ERR_CODE             status (ERR: 1 bad mode, 2 bad GPIO, 3 segment in use, 4 timeout)
// Optional feature: define SWAP_TIMEOUT_EN to bound WAIT_DONE to TimeoutCycles cycles.
module modulation_swap_requester #(
  parameter logic [31:0] TimeoutCycles = 32'd20_480_000,
  parameter int          NumSegment    = 2
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     CMD_VALID,
  output logic                     CMD_READY,
  input  logic                     CMD_SEGMENT,
  input  logic [7:0]               CMD_MODE,
  input  logic [63:0]              CMD_VALUE,
  input  logic [15:0]              CMD_REP,
  input  logic                     SEGMENT,
  input  logic                     STOP,
  output logic                     UPDATE_SETTINGS,
  output logic                     REQ_RD_SEGMENT,
  output logic [7:0]               TRANSITION_MODE,
  output logic [63:0]              TRANSITION_VALUE,
  output logic [16*NumSegment-1:0] REP,
  output logic                     BUSY,
  output logic                     DONE,
  output logic [2:0]               ERR_CODE
);

  localparam logic [7:0]  ModeSyncIdx = 8'h00;
  localparam logic [7:0]  ModeSysTime = 8'h01;
  localparam logic [7:0]  ModeGpio    = 8'h02;
  localparam logic [7:0]  ModeExt     = 8'hF0;
  localparam logic [15:0] RepInfinite = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        cmd_seg_q;
  logic [7:0]  cmd_mode_q;
  logic [63:0] cmd_value_q;
  logic [15:0] cmd_rep_q;
  logic [2:0]  check_code;
  logic        seg_done;
  logic        timeout_hit;

  // Reject reasons in priority order. A finite repeat aimed at the segment that
  // is currently playing (and not stopped) would cut it short, so it is refused.
  always_comb begin
    check_code = 3'd0;
    if (!(cmd_mode_q inside {ModeSyncIdx, ModeSysTime, ModeGpio, ModeExt}) ||
        (cmd_mode_q == ModeExt && cmd_rep_q != RepInfinite)) begin
      check_code = 3'd1;
    end else if (cmd_mode_q == ModeGpio && cmd_value_q > 64'd3) begin
      check_code = 3'd2;
    end else if (cmd_rep_q != RepInfinite && cmd_seg_q == SEGMENT && !STOP) begin
      check_code = 3'd3;
    end
  end

`ifdef SWAP_TIMEOUT_EN
  logic [31:0] wait_cnt_q;

  // Counter holds the number of WAIT_DONE cycles already spent.
  assign timeout_hit = (wait_cnt_q == TimeoutCycles - 32'd1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wait_cnt_q <= 32'd0;
    end else if (state_q == S_ISSUE) begin
      wait_cnt_q <= 32'd0;
    end else if (state_q == S_WAIT_DONE) begin
      wait_cnt_q <= wait_cnt_q + 32'd1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TimeoutCycles;
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    seg_done = 1'b0;
    case (state_q)
      S_IDLE:      if (CMD_VALID) state_d = S_CHECK;
      S_CHECK:     state_d = (check_code != 3'd0) ? S_IDLE : S_ISSUE;
      S_ISSUE:     state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        // Completion wins over a timeout landing on the same cycle.
        if (SEGMENT == cmd_seg_q && !STOP) begin
          seg_done = 1'b1;
          state_d  = S_IDLE;
        end else if (timeout_hit) begin
          state_d = S_IDLE;
        end
      end
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cmd_seg_q        <= 1'b0;
      cmd_mode_q       <= 8'd0;
      cmd_value_q      <= 64'd0;
      cmd_rep_q        <= 16'd0;
      ERR_CODE         <= 3'd0;
      UPDATE_SETTINGS  <= 1'b0;
      REQ_RD_SEGMENT   <= 1'b0;
      TRANSITION_MODE  <= 8'd0;
      TRANSITION_VALUE <= 64'd0;
      REP              <= {NumSegment{RepInfinite}};
    end else begin
      UPDATE_SETTINGS <= 1'b0;
      if (state_q == S_IDLE && CMD_VALID) begin
        cmd_seg_q   <= CMD_SEGMENT;
        cmd_mode_q  <= CMD_MODE;
        cmd_value_q <= CMD_VALUE;
        cmd_rep_q   <= CMD_REP;
        ERR_CODE    <= 3'd0;
      end
      // Settings are registered from the CHECK decision so they are already
      // stable in the same cycle the strobe is high.
      if (state_q == S_CHECK) begin
        if (check_code != 3'd0) begin
          ERR_CODE <= check_code;
        end else begin
          UPDATE_SETTINGS  <= 1'b1;
          REQ_RD_SEGMENT   <= cmd_seg_q;
          TRANSITION_MODE  <= cmd_mode_q;
          TRANSITION_VALUE <= cmd_value_q;
          for (int s = 0; s < NumSegment; s++) begin
            if (s == int'(cmd_seg_q)) REP[16*s +: 16] <= cmd_rep_q;
          end
        end
      end
      if (state_q == S_WAIT_DONE && !seg_done && timeout_hit) begin
        ERR_CODE <= 3'd4;
      end
    end
  end

  assign CMD_READY = (state_q == S_IDLE);
  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = seg_done;

endmodule
